// File: rtl/ptr_apply_arbiter_pkg.sv
// rtl/ptr_apply_arbiter_pkg.sv - shared constants for the pointer-apply arbiter
package ptr_apply_arbiter_pkg;

  // FSM state encoding
  localparam logic [0:0] ST_ARB   = 1'b0;
  localparam logic [0:0] ST_ISSUE = 1'b1;

  // Default field widths
  localparam int DEF_WQE_INDEX_WIDTH   = 10;
  localparam int DEF_WQE_SOURCE_LENGTH = 11;

endpackage

// File: rtl/syn_fifo.sv
// rtl/syn_fifo.sv - synchronous first-word-fall-through FIFO
module syn_fifo #(
  parameter int DATA_WIDTH = 2,
  parameter int DEPTH      = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wr_en_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rd_en_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  empty_o,
  output logic                  full_o
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]           wr_ptr_q, wr_ptr_d;
  logic [AW:0]           rd_ptr_q, rd_ptr_d;
  logic                  do_wr, do_rd;

  // Extra pointer bit distinguishes full from empty when the indices match
  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];
  assign do_wr     = wr_en_i && !full_o;
  assign do_rd     = rd_en_i && !empty_o;

  // Pointer advance on accepted write / read
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
  end

  // Pointer registers; reset empties the FIFO
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array, no reset needed since reads are qualified by empty
  always_ff @(posedge clk_i) begin
    if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
  end

endmodule

// File: rtl/ptr_apply_arbiter.sv
// rtl/ptr_apply_arbiter.sv - round-robin apply arbiter with in-order response steering
module ptr_apply_arbiter
  import ptr_apply_arbiter_pkg::*;
#(
  parameter int NUM_REQ           = 4,
  parameter int WQE_INDEX_WIDTH   = DEF_WQE_INDEX_WIDTH,
  parameter int WQE_SOURCE_LENGTH = DEF_WQE_SOURCE_LENGTH,
  parameter int MAX_OUTSTANDING   = 8
) (
  input  logic                               sys_clk,
  input  logic                               sys_rst,
  input  logic [NUM_REQ-1:0]                 s_axis_req_valid,
  input  logic [NUM_REQ*WQE_INDEX_WIDTH-1:0] s_axis_req_id,
  output logic [NUM_REQ-1:0]                 s_axis_req_ready,
  output logic                               m_axis_apply_valid,
  output logic [WQE_INDEX_WIDTH-1:0]         m_axis_apply_id,
  input  logic                               m_axis_apply_ready,
  input  logic                               s_axis_alloc_valid,
  input  logic [WQE_INDEX_WIDTH-1:0]         s_axis_alloc_id,
  input  logic [WQE_SOURCE_LENGTH-1:0]       s_axis_alloc_ptr,
  output logic                               s_axis_alloc_ready,
  output logic [NUM_REQ-1:0]                 m_axis_grant_valid,
  output logic [WQE_INDEX_WIDTH-1:0]         m_axis_grant_id,
  output logic [WQE_SOURCE_LENGTH-1:0]       m_axis_grant_ptr,
  input  logic [NUM_REQ-1:0]                 m_axis_grant_ready,
  output logic [$clog2(MAX_OUTSTANDING):0]   outstanding_cnt,
  output logic                               err_unexpected
);

  localparam int               IDX_W   = $clog2(NUM_REQ);
  localparam int               CNT_W   = $clog2(MAX_OUTSTANDING) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NUM_REQ - 1);

  logic [0:0]                 state_q, state_d;
  logic [IDX_W-1:0]           rr_q, rr_d;
  logic [IDX_W-1:0]           win_q, win_d;
  logic [WQE_INDEX_WIDTH-1:0] id_q, id_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic                       err_q, err_d;

  logic                       found;
  logic [IDX_W-1:0]           win_idx;
  logic                       grant_now;
  logic                       apply_hs;
  logic                       pop;
  logic [IDX_W-1:0]           head;
  logic                       tag_empty;
  logic                       tag_full;

  // Round-robin search: first valid requester at or after rr_q, wrapping
  always_comb begin
    int j;
    j       = 0;
    found   = 1'b0;
    win_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(rr_q) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!found && s_axis_req_valid[j]) begin
        found   = 1'b1;
        win_idx = IDX_W'(j);
      end
    end
  end

  // A grant needs a free outstanding slot; reset forces ready low
  assign grant_now        = !sys_rst && (state_q == ST_ARB) && (cnt_q < CNT_MAX) && !tag_full && found;
  assign s_axis_req_ready = grant_now ? (NUM_REQ'(1) << win_idx) : '0;
  assign apply_hs         = (state_q == ST_ISSUE) && m_axis_apply_ready;

  assign m_axis_apply_valid = (state_q == ST_ISSUE);
  assign m_axis_apply_id    = id_q;

  // FSM: ARB latches the winner, ISSUE holds it until the allocator accepts
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    win_d   = win_q;
    id_d    = id_q;
    if (grant_now) begin
      state_d = ST_ISSUE;
      win_d   = win_idx;
      id_d    = s_axis_req_id[int'(win_idx)*WQE_INDEX_WIDTH +: WQE_INDEX_WIDTH];
    end
    if (apply_hs) begin
      state_d = ST_ARB;
      rr_d    = (win_q == IDX_TOP) ? '0 : win_q + IDX_W'(1);
    end
  end

  // Responses come back in issue order, so the FIFO head names the target
  always_comb begin
    m_axis_grant_valid = '0;
    if (s_axis_alloc_valid && !tag_empty) m_axis_grant_valid = NUM_REQ'(1) << head;
  end

  // Responses with nothing outstanding are drained rather than left to stall
  assign s_axis_alloc_ready = tag_empty ? s_axis_alloc_valid : m_axis_grant_ready[head];
  assign pop                = s_axis_alloc_valid && !tag_empty && m_axis_grant_ready[head];
  assign m_axis_grant_id    = s_axis_alloc_id;
  assign m_axis_grant_ptr   = s_axis_alloc_ptr;

  // Outstanding count and sticky unexpected-response flag
  always_comb begin
    cnt_d = cnt_q;
    case ({apply_hs, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
    err_d = err_q | (s_axis_alloc_valid & tag_empty);
  end

  assign outstanding_cnt = cnt_q;
  assign err_unexpected  = err_q;

  // State registers; reset abandons any pending apply
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= ST_ARB;
      rr_q    <= '0;
      win_q   <= '0;
      id_q    <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      win_q   <= win_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  syn_fifo #(
    .DATA_WIDTH (IDX_W),
    .DEPTH      (MAX_OUTSTANDING)
  ) u_tag_fifo (
    .clk_i     (sys_clk),
    .rst_i     (sys_rst),
    .wr_en_i   (apply_hs),
    .wr_data_i (win_q),
    .rd_en_i   (pop),
    .rd_data_o (head),
    .empty_o   (tag_empty),
    .full_o    (tag_full)
  );

endmodule

// File: tb/tb_ptr_apply_arbiter.sv
// tb/tb_ptr_apply_arbiter.sv - directed self-checking bench for ptr_apply_arbiter
module tb_ptr_apply_arbiter;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic [3:0]  req_valid;
  logic [39:0] req_id;
  logic [3:0]  req_ready;
  logic        apply_valid;
  logic [9:0]  apply_id;
  logic        apply_ready;
  logic        alloc_valid;
  logic [9:0]  alloc_id;
  logic [10:0] alloc_ptr;
  logic        alloc_ready;
  logic [3:0]  grant_valid;
  logic [9:0]  grant_id;
  logic [10:0] grant_ptr;
  logic [3:0]  grant_ready;
  logic [3:0]  out_cnt;
  logic        err;

  int n_checks = 0;
  int n_errors = 0;
  int n_apply;
  int seen;

  always #5 sys_clk = ~sys_clk;

  ptr_apply_arbiter dut (
    .sys_clk            (sys_clk),
    .sys_rst            (sys_rst),
    .s_axis_req_valid   (req_valid),
    .s_axis_req_id      (req_id),
    .s_axis_req_ready   (req_ready),
    .m_axis_apply_valid (apply_valid),
    .m_axis_apply_id    (apply_id),
    .m_axis_apply_ready (apply_ready),
    .s_axis_alloc_valid (alloc_valid),
    .s_axis_alloc_id    (alloc_id),
    .s_axis_alloc_ptr   (alloc_ptr),
    .s_axis_alloc_ready (alloc_ready),
    .m_axis_grant_valid (grant_valid),
    .m_axis_grant_id    (grant_id),
    .m_axis_grant_ptr   (grant_ptr),
    .m_axis_grant_ready (grant_ready),
    .outstanding_cnt    (out_cnt),
    .err_unexpected     (err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit past the next rising edge
  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  initial begin
    sys_rst     = 1'b1;
    req_valid   = 4'hF;
    req_id      = {10'h013, 10'h012, 10'h011, 10'h010};
    apply_ready = 1'b1;
    alloc_valid = 1'b0;
    alloc_id    = '0;
    alloc_ptr   = '0;
    grant_ready = 4'hF;

    // Reset state, with every requester asking
    step(); step(); #1;
    check("rst_req_ready", 32'(req_ready), 32'h0);
    check("rst_apply_valid", 32'(apply_valid), 32'h0);
    check("rst_apply_id", 32'(apply_id), 32'h0);
    check("rst_cnt", 32'(out_cnt), 32'h0);
    check("rst_err", 32'(err), 32'h0);

    // Only requester 2, then 1 and 3: pointer must move past 2
    sys_rst = 1'b0; req_valid = 4'b0100; #1;
    check("a_ready2", 32'(req_ready), 32'h4);
    step(); req_valid = 4'b0000; #1;
    check("a_apply_valid", 32'(apply_valid), 32'h1);
    check("a_apply_id2", 32'(apply_id), 32'h12);
    check("a_issue_ready0", 32'(req_ready), 32'h0);
    step(); req_valid = 4'b1010; #1;
    check("a_ready3", 32'(req_ready), 32'h8);
    check("a_cnt1", 32'(out_cnt), 32'h1);
    step(); req_valid = 4'b0000; #1;
    check("a_apply_id3", 32'(apply_id), 32'h13);
    step();
    alloc_valid = 1'b1; alloc_id = 10'h012; alloc_ptr = 11'h055; #1;
    check("a_resp_grant2", 32'(grant_valid), 32'h4);
    check("a_resp_ready", 32'(alloc_ready), 32'h1);
    check("a_resp_ptr", 32'(grant_ptr), 32'h55);
    step(); alloc_id = 10'h013; alloc_ptr = 11'h066; #1;
    check("a_resp_grant3", 32'(grant_valid), 32'h8);
    check("a_resp_id", 32'(grant_id), 32'h13);
    step(); alloc_valid = 1'b0; #1;
    check("a_cnt0", 32'(out_cnt), 32'h0);

    // All four requesting: applies 0,1,2,3,0 one every two cycles
    req_valid = 4'hF;
    for (int k = 0; k < 10; k++) begin
      #1;
      check("b_apply_valid", 32'(apply_valid), 32'(k % 2));
      if (k % 2 == 1) check("b_apply_id", 32'(apply_id), 32'h10 + 32'((k / 2) % 4));
      else            check("b_ready", 32'(req_ready), 32'h1 << ((k / 2) % 4));
      step();
    end
    req_valid = 4'h0; #1;
    check("b_cnt5", 32'(out_cnt), 32'h5);

    // Head 0 delivered, then head 1 blocked for 5 cycles
    alloc_valid = 1'b1; alloc_id = 10'h010; alloc_ptr = 11'h001; #1;
    check("c_grant0", 32'(grant_valid), 32'h1);
    step();
    alloc_id = 10'h011; alloc_ptr = 11'h02A; grant_ready = 4'b1101;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("c_block_ready", 32'(alloc_ready), 32'h0);
      check("c_block_cnt", 32'(out_cnt), 32'h4);
      step();
    end
    grant_ready = 4'hF; #1;
    check("c_rel_ready", 32'(alloc_ready), 32'h1);
    check("c_rel_grant1", 32'(grant_valid), 32'h2);
    check("c_rel_ptr", 32'(grant_ptr), 32'h2A);
    step();
    for (int k = 0; k < 3; k++) begin
      #1;
      check("c_drain_grant", 32'(grant_valid), 32'h1 << ((k + 2) % 4));
      step();
    end
    alloc_valid = 1'b0; #1;
    check("c_cnt0", 32'(out_cnt), 32'h0);

    // No responses: exactly MAX_OUTSTANDING applies, then one more after a response
    req_valid = 4'hF; n_apply = 0;
    for (int k = 0; k < 40; k++) begin
      #1;
      if (apply_valid) n_apply++;
      step();
    end
    #1;
    check("d_apply_count", 32'(n_apply), 32'h8);
    check("d_cnt8", 32'(out_cnt), 32'h8);
    check("d_ready0", 32'(req_ready), 32'h0);
    alloc_valid = 1'b1; alloc_id = 10'h011; alloc_ptr = 11'h007; #1;
    check("d_resp_grant1", 32'(grant_valid), 32'h2);
    step(); alloc_valid = 1'b0;
    seen = 0;
    for (int k = 0; k < 6 && seen == 0; k++) begin
      #1;
      if (apply_valid) begin
        seen = 1;
        check("d_ninth_id", 32'(apply_id), 32'h11);
      end
      step();
    end
    req_valid = 4'h0;
    check("d_ninth_seen", 32'(seen), 32'h1);
    check("d_cnt8_again", 32'(out_cnt), 32'h8);
    alloc_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      check("d_drain_ready", 32'(alloc_ready), 32'h1);
      step();
    end
    alloc_valid = 1'b0; #1;
    check("d_cnt0", 32'(out_cnt), 32'h0);
    check("d_err0", 32'(err), 32'h0);

    // Response with nothing outstanding: drained, flagged, sticky
    alloc_valid = 1'b1; #1;
    check("e_ready", 32'(alloc_ready), 32'h1);
    check("e_grant0", 32'(grant_valid), 32'h0);
    step(); alloc_valid = 1'b0; #1;
    check("e_err1", 32'(err), 32'h1);
    step(); step(); #1;
    check("e_err_sticky", 32'(err), 32'h1);
    sys_rst = 1'b1; step(); sys_rst = 1'b0; #1;
    check("e_err_cleared", 32'(err), 32'h0);

    // Reset while an apply is pending
    req_valid = 4'b0001; apply_ready = 1'b0;
    step(); #1;
    check("f_issue", 32'(apply_valid), 32'h1);
    step(); #1;
    check("f_hold_valid", 32'(apply_valid), 32'h1);
    check("f_hold_id", 32'(apply_id), 32'h10);
    sys_rst = 1'b1; req_valid = 4'h0;
    step(); #1;
    check("f_rst_valid", 32'(apply_valid), 32'h0);
    check("f_rst_cnt", 32'(out_cnt), 32'h0);
    check("f_rst_id", 32'(apply_id), 32'h0);
    sys_rst = 1'b0; apply_ready = 1'b1;
    step(); #1;
    check("f_idle_arb", 32'(apply_valid), 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ptr_apply_arbiter.md
PTR_APPLY_ARBITER -- requirements
Module: ptr_apply_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of requesters (2..8).
REQ-002 SHALL have parameter WQE_INDEX_WIDTH, default 10: WQE id width.
REQ-003 SHALL have parameter WQE_SOURCE_LENGTH, default 11: buffer pointer width.
REQ-004 SHALL have parameter MAX_OUTSTANDING, default 8: maximum issued-but-unanswered applies (power of 2).
REQ-005 SHALL have port sys_clk, input, 1: sole clock; all logic is rising-edge.
REQ-006 SHALL have port sys_rst, input, 1: reset, synchronous, active-high.
REQ-007 SHALL have port s_axis_req_valid, input, NUM_REQ: per-requester apply request.
REQ-008 SHALL have port s_axis_req_id, input, NUM_REQ*WQE_INDEX_WIDTH: per-requester WQE id; requester i uses slice i.
REQ-009 SHALL have port s_axis_req_ready, output, NUM_REQ: per-requester accept.
REQ-010 SHALL have port m_axis_apply_valid, output, 1: apply request to the pointer allocator.
REQ-011 SHALL have port m_axis_apply_id, output, WQE_INDEX_WIDTH: WQE id sent to the allocator.
REQ-012 SHALL have port m_axis_apply_ready, input, 1: allocator accept.
REQ-013 SHALL have port s_axis_alloc_valid, input, 1: allocated-pointer response, in issue order.
REQ-014 SHALL have port s_axis_alloc_id, input, WQE_INDEX_WIDTH: WQE id of the response.
REQ-015 SHALL have port s_axis_alloc_ptr, input, WQE_SOURCE_LENGTH: allocated buffer pointer.
REQ-016 SHALL have port s_axis_alloc_ready, output, 1: response accept.
REQ-017 SHALL have port m_axis_grant_valid, output, NUM_REQ: per-requester response valid.
REQ-018 SHALL have port m_axis_grant_id, output, WQE_INDEX_WIDTH: shared response id.
REQ-019 SHALL have port m_axis_grant_ptr, output, WQE_SOURCE_LENGTH: shared response pointer.
REQ-020 SHALL have port m_axis_grant_ready, input, NUM_REQ: per-requester response accept.
REQ-021 SHALL have port outstanding_cnt, output, clog2(MAX_OUTSTANDING)+1: issued-unanswered count.
REQ-022 SHALL have port err_unexpected, output, 1: sticky flag for a response received with no outstanding apply.

Function
REQ-023 The FSM SHALL have two states: ARB and ISSUE.
REQ-024 In ARB, when any req_valid is set and outstanding_cnt < MAX_OUTSTANDING, the winner SHALL be the first valid index at or after rr_ptr, searching round-robin with wrap from NUM_REQ-1 to 0.
REQ-025 The winner's s_axis_req_ready SHALL be driven combinationally high in that cycle, with all other ready bits low; the winner's id and index SHALL be registered; the FSM SHALL move to ISSUE.
REQ-026 s_axis_req_ready SHALL be all-zero in ISSUE and whenever outstanding_cnt == MAX_OUTSTANDING.
REQ-027 In ISSUE, m_axis_apply_valid SHALL be 1 and m_axis_apply_id SHALL be held stable until m_axis_apply_ready.
REQ-028 On the apply handshake, the winner index SHALL be pushed to the tag FIFO, rr_ptr SHALL become (winner+1) mod NUM_REQ, and the FSM SHALL return to ARB.
REQ-029 Peak issue rate SHALL be one apply per 2 cycles.
REQ-030 The response path SHALL be combinational with zero latency: grant_valid[i] = alloc_valid AND tag FIFO not empty AND head == i.
REQ-031 grant_id and grant_ptr SHALL equal alloc_id and alloc_ptr.
REQ-032 alloc_ready SHALL equal grant_ready[head] AND tag FIFO not empty.
REQ-033 On a response handshake, the tag FIFO SHALL be popped.
REQ-034 A blocked head requester SHALL stall all responses, preserving in-order delivery.
REQ-035 When alloc_valid is high and the tag FIFO is empty, alloc_ready SHALL be 1 (drain), no grant_valid bit SHALL be set, and err_unexpected SHALL be set until reset.
REQ-036 outstanding_cnt SHALL be +1 on apply handshake only, -1 on response pop only, and unchanged when both occur in the same cycle.
REQ-037 A requester deasserting valid while not granted SHALL NOT be an error; it drops out of arbitration.

Reset
REQ-038 On sys_rst=1 at a clock edge, the following SHALL reset: FSM=ARB, rr_ptr=0, tag FIFO empty, outstanding_cnt=0, err_unexpected=0, m_axis_apply_valid=0, m_axis_apply_id=0, s_axis_req_ready=0.
REQ-039 A reset asserted during ISSUE SHALL abandon the pending apply; responses already in flight are the system's responsibility to flush.

Structure
REQ-040 Shared package SHALL hold: FSM state encoding (ARB=0, ISSUE=1) and the default widths WQE_INDEX_WIDTH=10, WQE_SOURCE_LENGTH=11.
REQ-041 The tag FIFO SHALL be the existing syn_fifo (DATA_WIDTH=clog2(NUM_REQ), depth MAX_OUTSTANDING), instanced once; no other sub-modules.

Verification
REQ-042 Requesters 0..3 held valid with ids 0x10..0x13, allocator always ready, responses returned in order -> applies issued in order 0,1,2,3,0, one every 2 cycles.
REQ-043 Only requester 2 valid after reset -> grant to 2; rr_ptr=3; next grant with requesters 1 and 3 valid goes to 3.
REQ-044 MAX_OUTSTANDING=8 with no responses -> exactly 8 applies issued, outstanding_cnt=8, all s_axis_req_ready=0; one response returns -> a 9th apply is issued.
REQ-045 Head tag = 1, grant_ready[1]=0 for 5 cycles -> alloc_ready=0 for those cycles; ptr 0x2A delivered to requester 1 only on the release cycle.
REQ-046 alloc_valid with outstanding_cnt=0 -> alloc_ready=1, grant_valid=0, err_unexpected=1 until sys_rst.
REQ-047 sys_rst asserted in ISSUE -> next cycle m_axis_apply_valid=0, state ARB, outstanding_cnt=0.
